// File: rtl/ll_pkg.sv
// Shared types for the linked-list subsystem: pool size, node index width
// and the allocator state encoding.
package ll_pkg;

    localparam int NODES_DEFAULT = 16;

    function automatic int ptr_w(input int nodes);
        return (nodes > 1) ? $clog2(nodes) : 1;
    endfunction

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

endpackage

// File: rtl/ll_free_list_if.sv
// Allocate/free handshake between the linked-list engine (master) and the
// free-node allocator (slave).
interface ll_free_list_if
    import ll_pkg::*;
#(
    parameter int NODES = NODES_DEFAULT,
    parameter int PTR_W = ptr_w(NODES)
);

    logic             alloc_req;
    logic             alloc_gnt;
    logic [PTR_W-1:0] alloc_ptr;
    logic             free_vld;
    logic [PTR_W-1:0] free_ptr;
    logic             free_rdy;
    logic [PTR_W:0]   free_cnt;
    logic             init_done;
    logic             err;
    logic             err_clr;

    modport master (
        output alloc_req, free_vld, free_ptr, err_clr,
        input  alloc_gnt, alloc_ptr, free_rdy, free_cnt, init_done, err
    );

    modport slave (
        input  alloc_req, free_vld, free_ptr, err_clr,
        output alloc_gnt, alloc_ptr, free_rdy, free_cnt, init_done, err
    );

endinterface

// File: rtl/ll_ptr_fifo.sv
// Circular FIFO of free node indices with wrapping head/tail and an
// occupancy count one bit wider than an index.
module ll_ptr_fifo
    import ll_pkg::*;
#(
    parameter int NODES = NODES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [ptr_w(NODES)-1:0]    push_data_i,
    input  logic                       pop_i,
    output logic [ptr_w(NODES)-1:0]    head_data_o,
    output logic [ptr_w(NODES):0]      count_o
);

    localparam int PTR_W = ptr_w(NODES);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [PTR_W-1:0] mem_q [NODES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // NOTE: the storage array carries no reset; every slot is rewritten by the
    // init sweep before it can be read, and the output is gated while empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_i) begin
            head_d = head_q + PTR_ONE;
        end
        if (push_i) begin
            tail_d = tail_q + PTR_ONE;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data_o = (count_q != '0) ? mem_q[head_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/ll_free_list.sv
// Free-node allocator: init sweep FSM, per-node allocated bitmap and sticky
// illegal-free error on top of the circular pointer FIFO.
module ll_free_list
    import ll_pkg::*;
#(
    parameter int NODES = NODES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    ll_free_list_if.slave  bus
);

    localparam int PTR_W = ptr_w(NODES);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NODES - 1);

    state_e           state_q;
    logic [PTR_W-1:0] init_cnt_q;
    logic             init_done_q;
    logic             free_rdy_q;
    logic [NODES-1:0] bitmap_q, bitmap_d;
    logic             err_q, err_d;

    logic             ready;
    logic             alloc_gnt;
    logic             free_legal;
    logic             free_illegal;
    logic             push;
    logic [PTR_W-1:0] push_data;
    logic [PTR_W-1:0] head_data;
    logic [PTR_W:0]   count;

    assign ready        = (state_q == S_READY);
    assign alloc_gnt    = ready && bus.alloc_req && (count != '0);
    // A free of the index granted this same cycle sees its bit still clear and is dropped.
    assign free_legal   = ready && bus.free_vld &&  bitmap_q[bus.free_ptr];
    assign free_illegal = ready && bus.free_vld && !bitmap_q[bus.free_ptr];

    assign push      = !ready || free_legal;
    assign push_data = ready ? bus.free_ptr : init_cnt_q;

    ll_ptr_fifo #(.NODES(NODES)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (alloc_gnt),
        .head_data_o (head_data),
        .count_o     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            free_rdy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + PTR_ONE;
                    if (init_cnt_q == LAST_IDX) begin
                        state_q     <= S_READY;
                        init_done_q <= 1'b1;
                        free_rdy_q  <= 1'b1;
                    end
                end
                S_READY: state_q <= S_READY;
                default: state_q <= S_INIT;
            endcase
        end
    end

    always_comb begin
        bitmap_d = bitmap_q;
        if (alloc_gnt) begin
            bitmap_d[head_data] = 1'b1;
        end
        if (free_legal) begin
            bitmap_d[bus.free_ptr] = 1'b0;
        end
        err_d = err_q;
        if (free_illegal) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q <= '0;
            err_q    <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            err_q    <= err_d;
        end
    end

    assign bus.alloc_gnt = alloc_gnt;
    assign bus.alloc_ptr = head_data;
    assign bus.free_rdy  = free_rdy_q;
    assign bus.free_cnt  = count;
    assign bus.init_done = init_done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ll_free_list.sv
// Directed bench for ll_free_list (NODES=8): queue-based reference model checked
// every falling edge, plus hand-computed expectations along the stimulus.
module tb_ll_free_list;

    localparam int NODES = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    ll_free_list_if #(.NODES(NODES)) bus ();

    ll_free_list #(.NODES(NODES)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of free indices, an allocated flag per node,
    // the number of init cycles done and the sticky error bit.
    int m_q[$];
    bit m_alloc[NODES];
    int m_init = 0;
    bit m_err  = 1'b0;

    bit u_gnt, u_legal, u_illegal;
    int u_ptr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < NODES; i++) m_alloc[i] = 1'b0;
            m_init = 0;
            m_err  = 1'b0;
        end else if (m_init < NODES) begin
            m_q.push_back(m_init);
            m_init++;
        end else begin
            u_gnt     = bus.alloc_req && (m_q.size() > 0);
            u_legal   = bus.free_vld &&  m_alloc[int'(bus.free_ptr)];
            u_illegal = bus.free_vld && !m_alloc[int'(bus.free_ptr)];
            if (u_gnt) begin
                u_ptr = m_q.pop_front();
                m_alloc[u_ptr] = 1'b1;
            end
            if (u_legal) begin
                m_q.push_back(int'(bus.free_ptr));
                m_alloc[int'(bus.free_ptr)] = 1'b0;
            end
            if (u_illegal) m_err = 1'b1;
            else if (bus.err_clr) m_err = 1'b0;
        end
    end

    bit e_rdy;
    int e_head;

    always @(negedge clk) begin
        e_rdy  = (m_init == NODES);
        e_head = (m_q.size() > 0) ? m_q[0] : 0;
        check("model_gnt",       int'(bus.alloc_gnt), int'(e_rdy && bus.alloc_req && m_q.size() > 0));
        check("model_ptr",       int'(bus.alloc_ptr), e_head);
        check("model_free_cnt",  int'(bus.free_cnt),  m_q.size());
        check("model_free_rdy",  int'(bus.free_rdy),  int'(e_rdy));
        check("model_init_done", int'(bus.init_done), int'(e_rdy));
        check("model_err",       int'(bus.err),       int'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit req, input bit fv, input int fp, input bit clr);
        bus.alloc_req = req;
        bus.free_vld  = fv;
        bus.free_ptr  = fp[2:0];
        bus.err_clr   = clr;
        #1;
    endtask

    initial begin
        bus.alloc_req = 1'b0;
        bus.free_vld  = 1'b0;
        bus.free_ptr  = '0;
        bus.err_clr   = 1'b0;
        repeat (2) tick();

        // Reset values while rst_n is held low.
        drive(1, 0, 0, 0);
        check("rst_gnt", int'(bus.alloc_gnt), 0);
        check("rst_cnt", int'(bus.free_cnt), 0);
        check("rst_init_done", int'(bus.init_done), 0);
        check("rst_free_rdy", int'(bus.free_rdy), 0);
        check("rst_err", int'(bus.err), 0);
        rst_n = 1'b1;

        // Init sweep: requests ignored for NODES cycles.
        for (int i = 0; i < NODES; i++) begin
            drive(1, 0, 0, 0);
            check("init_done_low", int'(bus.init_done), 0);
            check("init_no_gnt", int'(bus.alloc_gnt), 0);
            check("init_cnt", int'(bus.free_cnt), i);
            tick();
        end

        // Drain to empty, indices in order.
        for (int i = 0; i < NODES; i++) begin
            drive(1, 0, 0, 0);
            check("drain_init_done", int'(bus.init_done), 1);
            check("drain_gnt", int'(bus.alloc_gnt), 1);
            check("drain_ptr", int'(bus.alloc_ptr), i);
            check("drain_cnt", int'(bus.free_cnt), NODES - i);
            tick();
        end
        drive(1, 0, 0, 0);
        check("empty_gnt", int'(bus.alloc_gnt), 0);
        check("empty_cnt", int'(bus.free_cnt), 0);
        tick();
        check("empty_err", int'(bus.err), 0);

        // Free ordering.
        drive(0, 1, 5, 0);
        check("ord_cnt0", int'(bus.free_cnt), 0);
        tick();
        drive(0, 1, 2, 0);
        check("ord_cnt1", int'(bus.free_cnt), 1);
        tick();
        drive(1, 0, 0, 0);
        check("ord_gnt_a", int'(bus.alloc_gnt), 1);
        check("ord_ptr_a", int'(bus.alloc_ptr), 5);
        check("ord_cnt2", int'(bus.free_cnt), 2);
        tick();
        drive(1, 0, 0, 0);
        check("ord_ptr_b", int'(bus.alloc_ptr), 2);
        check("ord_cnt1b", int'(bus.free_cnt), 1);
        tick();
        drive(0, 0, 0, 0);
        check("ord_cnt0b", int'(bus.free_cnt), 0);

        // Double free of node 3.
        drive(0, 1, 3, 0);
        tick();
        drive(1, 0, 0, 0);
        check("dbl_alloc_ptr", int'(bus.alloc_ptr), 3);
        tick();
        drive(0, 1, 3, 0);
        check("dbl_cnt_a", int'(bus.free_cnt), 0);
        tick();
        drive(0, 1, 3, 0);
        check("dbl_cnt_b", int'(bus.free_cnt), 1);
        check("dbl_err_before", int'(bus.err), 0);
        tick();
        drive(0, 0, 0, 1);
        check("dbl_err_set", int'(bus.err), 1);
        check("dbl_cnt_kept", int'(bus.free_cnt), 1);
        tick();
        drive(0, 0, 0, 0);
        check("dbl_err_clr", int'(bus.err), 0);

        // Queue holds [3]; swap it for node 4 with a same-cycle alloc+free.
        drive(1, 1, 4, 0);
        check("sim_ptr3", int'(bus.alloc_ptr), 3);
        tick();
        drive(1, 1, 6, 0);
        check("sim_gnt", int'(bus.alloc_gnt), 1);
        check("sim_ptr4", int'(bus.alloc_ptr), 4);
        check("sim_cnt", int'(bus.free_cnt), 1);
        tick();
        drive(1, 0, 0, 0);
        check("sim_cnt_after", int'(bus.free_cnt), 1);
        check("sim_ptr6", int'(bus.alloc_ptr), 6);
        tick();

        // No bypass when empty.
        drive(1, 1, 7, 0);
        check("nobyp_gnt", int'(bus.alloc_gnt), 0);
        tick();
        drive(1, 0, 0, 0);
        check("nobyp_gnt_next", int'(bus.alloc_gnt), 1);
        check("nobyp_ptr", int'(bus.alloc_ptr), 7);
        tick();

        // Freeing the index granted in the same cycle is illegal.
        drive(0, 1, 7, 0);
        tick();
        drive(1, 1, 7, 0);
        check("self_ptr", int'(bus.alloc_ptr), 7);
        tick();
        drive(0, 0, 0, 0);
        check("self_err", int'(bus.err), 1);
        check("self_cnt", int'(bus.free_cnt), 0);

        // Refill 0..4, allocate five, then reset asynchronously mid-cycle.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, k, 0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0);
            check("pre_rst_ptr", int'(bus.alloc_ptr), k);
            tick();
        end
        drive(1, 0, 0, 0);
        check("pre_rst_err", int'(bus.err), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", int'(bus.alloc_gnt), 0);
        check("mid_rst_cnt", int'(bus.free_cnt), 0);
        check("mid_rst_init_done", int'(bus.init_done), 0);
        check("mid_rst_free_rdy", int'(bus.free_rdy), 0);
        check("mid_rst_err", int'(bus.err), 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("resweep_init_done", int'(bus.init_done), 0);
        check("resweep_gnt", int'(bus.alloc_gnt), 0);
        repeat (NODES - 1) tick();
        drive(1, 0, 0, 0);
        check("resweep_done", int'(bus.init_done), 1);
        check("resweep_cnt", int'(bus.free_cnt), NODES);
        check("resweep_ptr", int'(bus.alloc_ptr), 0);
        tick();
        drive(0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ll_free_list.md
Name: ll_free_list

Overview:
- Node allocator that sits directly upstream of the linked-list engine.
- Owns the pool of free node indices. Hands one index per cycle to the list engine on allocate, and takes indices back on free.
- Keeps a per-node allocated bitmap so that illegal frees (double free, out of range) are caught and dropped.
- After reset, runs an init sweep that loads every index before it accepts any traffic.

Parameters:
- NODES, 16, number of list nodes in the pool; must be a power of two, ≥ 2.
- PTR_W, $clog2(NODES), width of a node index.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- alloc_req  in  1  list engine requests a free node
- alloc_gnt  out  1  request granted this cycle; alloc_ptr valid
- alloc_ptr  out  PTR_W  granted node index
- free_vld  in  1  list engine returns a node
- free_ptr  in  PTR_W  returned node index
- free_rdy  out  1  free port accepting (READY state)
- free_cnt  out  PTR_W+1  number of nodes currently free
- init_done  out  1  init sweep complete
- err  out  1  sticky illegal-free flag
- err_clr  in  1  clears err

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - All state is cleared at reset assertion, independent of clk.
- Reset values:
  - alloc_gnt=0, alloc_ptr=0, free_rdy=0, free_cnt=0, init_done=0, err=0.
  - Bitmap all zero, head=tail=0, state=INIT, init counter=0.
- Storage:
  - Circular FIFO, NODES entries × PTR_W bits.
  - Head and tail pointers are PTR_W bits and wrap naturally.
  - Count is PTR_W+1 bits; free_cnt = count.
- State machine INIT:
  - Each cycle writes fifo[i]=i and increments i and count.
  - After writing NODES-1, moves to READY. The sweep takes exactly NODES cycles after reset release.
  - Alloc and free are ignored in INIT: alloc_gnt=0, free_rdy=0.
- State machine READY:
  - init_done=1, free_rdy=1.
  - Stays in READY until reset; there is no other exit.
- Allocate:
  - alloc_gnt = READY & alloc_req & (count≠0). Combinational, zero latency.
  - alloc_ptr = fifo[head] combinationally. It is 0 when count=0 and is meaningful only when alloc_gnt=1.
  - On grant: head++, count--, bitmap[alloc_ptr] set at the clock edge.
- Free, legal case:
  - Legal when READY, free_vld=1 and bitmap[free_ptr]=1.
  - Action: fifo[tail]=free_ptr, tail++, count++, bitmap[free_ptr] cleared.
- Free, illegal case:
  - Illegal when free_vld=1 in READY and bitmap[free_ptr]=0. This covers double free and freeing a never-allocated node.
  - The entry is dropped: no FIFO write, no count change. err is set next cycle.
  - Because NODES is a power of two, every free_ptr value is in range, so bitmap=0 is the only check needed.
- Simultaneous alloc and free in one cycle:
  - Both take effect and count is unchanged.
  - A free whose free_ptr equals the alloc_ptr granted in the same cycle is illegal (that bit is still 0) and is dropped.
  - No bypass: when count=0, a same-cycle free does not satisfy the alloc. alloc_gnt stays 0 and the grant comes the next cycle.
- Full and empty:
  - count≤NODES is guaranteed by the bitmap check, since a legal free implies count<NODES.
  - When empty, alloc_req is held with no grant and no error.
- err:
  - Sticky.
  - err_clr=1 clears it next cycle, unless an illegal free occurs in the same cycle, in which case set wins.
- Reset mid-operation:
  - Every outstanding node is reclaimed, the bitmap is cleared, and the INIT sweep reruns.
  - The list engine shares the same reset and must treat all its pointers as void.

Decomposition:
- Shared package ll_pkg holds:
  - NODES_DEFAULT
  - PTR_W derivation
  - the state encoding enum {S_INIT, S_READY}
- The list engine reuses the same package for node index width.
- One natural sub-module, ll_ptr_fifo: the circular pointer FIFO with head/tail/count. ll_free_list adds the FSM, bitmap and error logic on top.

Test Plan (NODES=8):
1. Init sweep: release rst_n; hold alloc_req=1 throughout → alloc_gnt=0 and init_done=0 for 8 cycles. Then init_done=1, free_cnt=8, and the first grants are alloc_ptr 0, 1, 2, … on consecutive cycles.
2. Drain to empty: 8 consecutive grants return 0..7 with free_cnt 7..0. A 9th request gives alloc_gnt=0 and err stays 0.
3. Free ordering: free 5, then 2, then allocate twice → alloc_ptr=5 then 2, with free_cnt 0→1→2→1→0.
4. Double free: allocate 3, free 3, free 3 again → the second free is dropped, err=1 the next cycle, free_cnt is unchanged. err_clr=1 → err=0.
5. Simultaneous alloc and free with count=1 (node 4 free), free_vld with free_ptr=6 (allocated) → alloc_ptr=4, 6 is enqueued, and free_cnt stays 1.
6. Mid-operation reset: after 5 allocs, pulse rst_n low asynchronously between edges → outputs go to reset values immediately. The init sweep reruns and free_cnt returns to 8.
